keypad_digit_loader: RTL and testbench



---
 rtl/keypad_pkg.sv | 7 +
 rtl/loadn_edge.sv | 15 +
 rtl/keypad_digit_loader.sv | 51 +++++
 tb/tb_keypad_digit_loader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared BCD type and limits for keypad encoder, digit loader and timer
package keypad_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam logic LOADN_IDLE = 1'b1;
endpackage

// File: rtl/loadn_edge.sv
// loadn_edge: falling-edge strobe on active-low loadn (in: clock, resetn, loadn; out: strobe)
module loadn_edge
  import keypad_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic loadn,
  output logic strobe
);
  logic loadn_q;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) loadn_q <= LOADN_IDLE;
    else loadn_q <= loadn;
  assign strobe = loadn_q & ~loadn;
endmodule

// File: rtl/keypad_digit_loader.sv
// keypad_digit_loader: BCD key strobes shifted into a right-justified time-entry register (in: clock, resetn, BCD, loadn, en, clear; out: digits, count, zero, time_valid, load_pulse, bad_digit)
module keypad_digit_loader
  import keypad_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [3:0]          BCD,
  input  logic                loadn,
  input  logic                en,
  input  logic                clear,
  output logic [4*DIGITS-1:0] digits,
  output logic [2:0]          count,
  output logic                zero,
  output logic                time_valid,
  output logic                load_pulse,
  output logic                bad_digit
);
  logic strobe, take, accept, reject;
  loadn_edge u_edge (
    .clock (clock),
    .resetn(resetn),
    .loadn (loadn),
    .strobe(strobe)
  );
  always_comb begin
    take = strobe & en & ~clear;
    accept = take & (bcd_t'(BCD) <= BCD_MAX);
    reject = take & (bcd_t'(BCD) > BCD_MAX);
    zero = digits == '0;
    time_valid = digits[7:4] <= SEC_TENS_MAX;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      digits <= '0;
      count <= '0;
      load_pulse <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      load_pulse <= accept;
      bad_digit <= reject;
      if (clear) begin
        digits <= '0;
        count <= '0;
      end else if (accept) begin
        digits <= {digits[4*DIGITS-5:0], BCD};
        count <= count == 3'(DIGITS) ? count : count + 3'd1;
      end
    end
endmodule

// File: tb/tb_keypad_digit_loader.sv
// tb_keypad_digit_loader: vector table, hand sequences and randomized model check of keypad_digit_loader
module tb_keypad_digit_loader;
  localparam int D = 3;
  logic clock = 1'b0, resetn = 1'b0;
  logic [3:0] BCD = 4'd0;
  logic loadn = 1'b1, en = 1'b0, clear = 1'b0;
  logic [4*D-1:0] digits;
  logic [2:0] count;
  logic zero, time_valid, load_pulse, bad_digit;
  logic [18:0] act;
  int n_cmp = 0, n_bad = 0, pulses = 0;
  int md[D];
  int mc;
  bit mp;
  bit mlp, mbd;

  always #5 clock = ~clock;

  keypad_digit_loader #(.DIGITS(D)) dut (
    .clock(clock), .resetn(resetn), .BCD(BCD), .loadn(loadn), .en(en), .clear(clear),
    .digits(digits), .count(count), .zero(zero), .time_valid(time_valid),
    .load_pulse(load_pulse), .bad_digit(bad_digit)
  );

  assign act = {digits, count, zero, time_valid, load_pulse, bad_digit};

  typedef struct {
    logic [3:0] bcd;
    logic ld, e, c;
    logic [11:0] d;
    int cnt;
    logic lp, bd;
  } vec_t;
  vec_t tbl[22];

  function automatic logic [18:0] pack(logic [11:0] d, int c, logic lp, logic bd);
    pack = {d, 3'(c), d == 12'h000, d[7:4] <= 4'd5, lp, bd};
  endfunction

  task automatic check(string name, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic logic [18:0] model_exp();
    logic [11:0] d;
    d = '0;
    for (int i = 0; i < D; i++) d[4*i +: 4] = 4'(md[i]);
    model_exp = pack(d, mc, mlp, mbd);
  endfunction

  task automatic model_step(int b, bit ld, bit e, bit c);
    bit s;
    s = mp && !ld && e && !c;
    mlp = s && b <= 9;
    mbd = s && b > 9;
    if (c) begin
      for (int i = 0; i < D; i++) md[i] = 0;
      mc = 0;
    end else if (mlp) begin
      for (int i = D - 1; i > 0; i--) md[i] = md[i-1];
      md[0] = b;
      mc = mc < D ? mc + 1 : D;
    end
    mp = ld;
  endtask

  task automatic do_reset();
    resetn = 1'b0; loadn = 1'b1; en = 1'b0; clear = 1'b0; BCD = 4'd0;
    @(posedge clock); #1;
    check("reset", act, pack(12'h000, 0, 0, 0));
    resetn = 1'b1;
    for (int i = 0; i < D; i++) md[i] = 0;
    mc = 0; mp = 1'b1; mlp = 1'b0; mbd = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
    pulses += int'(load_pulse);
  endtask

  task automatic press(logic [3:0] b, int low, int high);
    BCD = b; loadn = 1'b0;
    repeat (low) tick();
    loadn = 1'b1;
    repeat (high) tick();
  endtask

  initial begin
    tbl[0]  = '{4'd1, 0, 1, 0, 12'h001, 1, 1, 0};
    tbl[1]  = '{4'd1, 0, 1, 0, 12'h001, 1, 0, 0};
    tbl[2]  = '{4'd1, 1, 1, 0, 12'h001, 1, 0, 0};
    tbl[3]  = '{4'd3, 0, 1, 0, 12'h013, 2, 1, 0};
    tbl[4]  = '{4'd3, 1, 1, 0, 12'h013, 2, 0, 0};
    tbl[5]  = '{4'd0, 0, 1, 0, 12'h130, 3, 1, 0};
    tbl[6]  = '{4'd0, 1, 1, 0, 12'h130, 3, 0, 0};
    tbl[7]  = '{4'd7, 0, 1, 0, 12'h307, 3, 1, 0};
    tbl[8]  = '{4'd7, 1, 1, 0, 12'h307, 3, 0, 0};
    tbl[9]  = '{4'd6, 0, 1, 0, 12'h076, 3, 1, 0};
    tbl[10] = '{4'd6, 1, 1, 0, 12'h076, 3, 0, 0};
    tbl[11] = '{4'hC, 0, 1, 0, 12'h076, 3, 0, 1};
    tbl[12] = '{4'hC, 0, 1, 0, 12'h076, 3, 0, 0};
    tbl[13] = '{4'hC, 1, 1, 0, 12'h076, 3, 0, 0};
    tbl[14] = '{4'd5, 0, 0, 0, 12'h076, 3, 0, 0};
    tbl[15] = '{4'd5, 0, 1, 0, 12'h076, 3, 0, 0};
    tbl[16] = '{4'd5, 1, 1, 0, 12'h076, 3, 0, 0};
    tbl[17] = '{4'd5, 0, 1, 0, 12'h765, 3, 1, 0};
    tbl[18] = '{4'd5, 1, 1, 0, 12'h765, 3, 0, 0};
    tbl[19] = '{4'd4, 0, 1, 1, 12'h000, 0, 0, 0};
    tbl[20] = '{4'd4, 1, 1, 0, 12'h000, 0, 0, 0};
    tbl[21] = '{4'd2, 0, 1, 0, 12'h002, 1, 1, 0};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      BCD = tbl[i].bcd; loadn = tbl[i].ld; en = tbl[i].e; clear = tbl[i].c;
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), act, pack(tbl[i].d, tbl[i].cnt, tbl[i].lp, tbl[i].bd));
    end

    do_reset();
    en = 1'b1; pulses = 0;
    press(4'd1, 10, 5);
    press(4'd3, 10, 5);
    press(4'd0, 10, 5);
    check("plan_digits", act, pack(12'h130, 3, 0, 0));
    check("plan_pulses", pulses, 3);

    do_reset();
    en = 1'b1;
    press(4'd4, 2, 2);
    press(4'd2, 2, 2);
    check("pre_reset", act, pack(12'h042, 2, 0, 0));
    loadn = 1'b0; BCD = 4'd9;
    #2 resetn = 1'b0;
    #1 check("async_reset", act, pack(12'h000, 0, 0, 0));
    repeat (2) @(posedge clock);
    #5 resetn = 1'b1;
    pulses = 0;
    tick();
    check("held_after_reset", act, pack(12'h009, 1, 1, 0));
    repeat (4) tick();
    check("held_single_pulse", pulses, 1);
    check("held_final", act, pack(12'h009, 1, 0, 0));

    do_reset();
    for (int k = 0; k < 500; k++) begin
      BCD = 4'($urandom_range(0, 12));
      loadn = 1'($urandom_range(0, 1));
      en = $urandom_range(0, 7) != 0;
      clear = $urandom_range(0, 19) == 0;
      @(posedge clock); #1;
      model_step(int'(BCD), loadn, en, clear);
      check($sformatf("rand%0d", k), act, model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
